cc_seq_alu: RTL

Multi-cycle, parametrised successor to the datapath ALU. It executes one operation per start request over a start/done handshake. Variable-amount shifts run iteratively at one bit per cycle, and an optional shift-add multiplier is available. The N/Z/V/C condition codes sit in a register that only the CC-suffixed operations update. The block sits between the register file operand buses and the writeback mux of the microprogrammed datapath, and the control unit sequences it through Busy/Done.

---
 rtl/cc_seq_alu_pkg.sv | 40 ++++
 rtl/cc_seq_alu_shifter.sv | 34 +++
 rtl/cc_seq_alu.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/cc_seq_alu_pkg.sv
// Shared opcodes, FSM encoding, shifter modes and flag indices for cc_seq_alu.
package cc_seq_alu_pkg;

  localparam logic [3:0] OP_ANDCC  = 4'b0000;
  localparam logic [3:0] OP_ORCC   = 4'b0001;
  localparam logic [3:0] OP_NORCC  = 4'b0010;
  localparam logic [3:0] OP_ADDCC  = 4'b0011;
  localparam logic [3:0] OP_SRL    = 4'b0100;
  localparam logic [3:0] OP_AND    = 4'b0101;
  localparam logic [3:0] OP_OR     = 4'b0110;
  localparam logic [3:0] OP_NOR    = 4'b0111;
  localparam logic [3:0] OP_ADD    = 4'b1000;
  localparam logic [3:0] OP_SUBCC  = 4'b1001;
  localparam logic [3:0] OP_SLL    = 4'b1010;
  localparam logic [3:0] OP_SRA    = 4'b1011;
  localparam logic [3:0] OP_SEXT13 = 4'b1100;
  localparam logic [3:0] OP_INC    = 4'b1101;
  localparam logic [3:0] OP_INCPC  = 4'b1110;
  localparam logic [3:0] OP_F      = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SH_SRL = 2'd0,
    SH_SLL = 2'd1,
    SH_SRA = 2'd2,
    SH_MUL = 2'd3
  } shift_mode_t;

  localparam int unsigned NUM_FLAGS = 4;
  localparam int unsigned FLAG_C    = 0;
  localparam int unsigned FLAG_V    = 1;
  localparam int unsigned FLAG_Z    = 2;
  localparam int unsigned FLAG_N    = 3;

endpackage

// File: rtl/cc_seq_alu_shifter.sv
// One iteration step of the sequential ALU: single-bit SRL/SLL/SRA, plus a
// shift-add multiply step when CC_SEQ_ALU_MUL_EN is defined.
module cc_seq_alu_shifter
  import cc_seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  shift_mode_t       mode,
  input  logic [WIDTH-1:0]  work,
`ifdef CC_SEQ_ALU_MUL_EN
  input  logic [WIDTH-1:0]  mcand,
  input  logic [WIDTH-1:0]  acc,
  output logic [WIDTH-1:0]  mcand_c,
  output logic [WIDTH-1:0]  acc_c,
`endif
  output logic [WIDTH-1:0]  work_c
);

  always_comb begin
    work_c = work;
    case (mode)
      SH_SRL: work_c = {1'b0, work[WIDTH-1:1]};
      SH_SLL: work_c = {work[WIDTH-2:0], 1'b0};
      SH_SRA: work_c = {work[WIDTH-1], work[WIDTH-1:1]};
      SH_MUL: work_c = {1'b0, work[WIDTH-1:1]};
    endcase
`ifdef CC_SEQ_ALU_MUL_EN
    // work holds the multiplier (consumed LSB first), mcand doubles each step
    mcand_c = {mcand[WIDTH-2:0], 1'b0};
    acc_c   = work[0] ? acc + mcand : acc;
`endif
  end

endmodule

// File: rtl/cc_seq_alu.sv
// Multi-cycle ALU with start/done handshake and N/Z/V/C register.
// Define CC_SEQ_ALU_MUL_EN to turn opcode 1111 into an iterative UMULCC.
module cc_seq_alu
  import cc_seq_alu_pkg::*;
#(
  parameter int unsigned DATAWIDTH_BUS           = 32,
  parameter int unsigned DATAWIDTH_ALU_SELECTION = 4,
  parameter int unsigned SHAMT_WIDTH             = $clog2(DATAWIDTH_BUS)
) (
  input  logic                               CC_SEQ_ALU_CLOCK_50,
  input  logic                               CC_SEQ_ALU_RESET_InLow,
  input  logic                               CC_SEQ_ALU_Start_InHigh,
  input  logic [DATAWIDTH_ALU_SELECTION-1:0] CC_SEQ_ALU_Selection_In,
  input  logic [DATAWIDTH_BUS-1:0]           CC_SEQ_ALU_DataBUSA_In,
  input  logic [DATAWIDTH_BUS-1:0]           CC_SEQ_ALU_DataBUSB_In,
  output logic [DATAWIDTH_BUS-1:0]           CC_SEQ_ALU_DataBUS_Out,
  output logic                               CC_SEQ_ALU_Busy_OutHigh,
  output logic                               CC_SEQ_ALU_Done_OutHigh,
  output logic                               CC_SEQ_ALU_Negative_OutHigh,
  output logic                               CC_SEQ_ALU_Zero_OutHigh,
  output logic                               CC_SEQ_ALU_Overflow_OutHigh,
  output logic                               CC_SEQ_ALU_Carry_OutHigh
);

  localparam int unsigned W     = DATAWIDTH_BUS;
  localparam int unsigned CNT_W = SHAMT_WIDTH + 1;

  logic                   clk, rst_n, start;
  logic [3:0]             sel;
  logic [W-1:0]           a, b;
  logic [SHAMT_WIDTH-1:0] shamt;

  assign clk   = CC_SEQ_ALU_CLOCK_50;
  assign rst_n = CC_SEQ_ALU_RESET_InLow;
  assign start = CC_SEQ_ALU_Start_InHigh;
  assign sel   = 4'(CC_SEQ_ALU_Selection_In);
  assign a     = CC_SEQ_ALU_DataBUSA_In;
  assign b     = CC_SEQ_ALU_DataBUSB_In;
  assign shamt = b[SHAMT_WIDTH-1:0];

  state_t                state, state_next;
  shift_mode_t           mode, mode_next;
  logic [W-1:0]          result, result_c, work, work_next, step_work_c;
  logic [NUM_FLAGS-1:0]  flags, flags_c, op_flags_c;
  logic [CNT_W-1:0]      cnt, cnt_next;
  logic                  busy, busy_c, done, done_c;
  logic [W-1:0]          op_res_c;
  logic                  op_cc_c, is_shift_c, multi_c;
  logic [W:0]            add_ext, sub_ext;
`ifdef CC_SEQ_ALU_MUL_EN
  logic [W-1:0]          mcand, mcand_next, acc, acc_next, step_mcand_c, step_acc_c;
`endif

  cc_seq_alu_shifter #(.WIDTH(W)) u_shifter (
    .mode    (mode),
    .work    (work),
`ifdef CC_SEQ_ALU_MUL_EN
    .mcand   (mcand),
    .acc     (acc),
    .mcand_c (step_mcand_c),
    .acc_c   (step_acc_c),
`endif
    .work_c  (step_work_c)
  );

  // Single-cycle result and flag candidates for the opcode on the bus
  always_comb begin
    add_ext    = {1'b0, a} + {1'b0, b};
    sub_ext    = {1'b0, a} - {1'b0, b};
    op_res_c   = a;
    op_cc_c    = 1'b0;
    op_flags_c = '0;
    case (sel)
      OP_ANDCC:  begin op_res_c = a & b;    op_cc_c = 1'b1; end
      OP_ORCC:   begin op_res_c = a | b;    op_cc_c = 1'b1; end
      OP_NORCC:  begin op_res_c = ~(a | b); op_cc_c = 1'b1; end
      OP_ADDCC: begin
        op_res_c           = add_ext[W-1:0];
        op_cc_c            = 1'b1;
        op_flags_c[FLAG_C] = add_ext[W];
        op_flags_c[FLAG_V] = (a[W-1] == b[W-1]) && (add_ext[W-1] != a[W-1]);
      end
      OP_SUBCC: begin
        op_res_c           = sub_ext[W-1:0];
        op_cc_c            = 1'b1;
        op_flags_c[FLAG_C] = sub_ext[W];
        op_flags_c[FLAG_V] = (a[W-1] != b[W-1]) && (sub_ext[W-1] != a[W-1]);
      end
      OP_AND:    op_res_c = a & b;
      OP_OR:     op_res_c = a | b;
      OP_NOR:    op_res_c = ~(a | b);
      OP_ADD:    op_res_c = add_ext[W-1:0];
      OP_SEXT13: op_res_c = {{(W-13){a[12]}}, a[12:0]};
      OP_INC:    op_res_c = a + W'(1);
      OP_INCPC:  op_res_c = a + W'(4);
`ifdef CC_SEQ_ALU_MUL_EN
      OP_F:      op_res_c = '0;
`else
      OP_F:      op_res_c = $signed(a) >>> 5;
`endif
      default:   op_res_c = a;
    endcase
    op_flags_c[FLAG_N] = op_res_c[W-1];
    op_flags_c[FLAG_Z] = (op_res_c == '0);
  end

  always_comb begin
    is_shift_c = (sel == OP_SRL) || (sel == OP_SLL) || (sel == OP_SRA);
    multi_c    = is_shift_c && (shamt != '0);
`ifdef CC_SEQ_ALU_MUL_EN
    if (sel == OP_F) multi_c = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_BUSY: if (cnt == CNT_W'(1)) state_next = ST_DONE;
      default: begin
        if (start) state_next = multi_c ? ST_BUSY : ST_DONE;
        else       state_next = ST_IDLE;
      end
    endcase
  end

  // Next values of the registered outputs and the iteration datapath
  always_comb begin
    result_c  = result;
    flags_c   = flags;
    work_next = work;
    cnt_next  = cnt;
    mode_next = mode;
    busy_c    = (state_next == ST_BUSY);
    done_c    = (state_next == ST_DONE);
`ifdef CC_SEQ_ALU_MUL_EN
    mcand_next = mcand;
    acc_next   = acc;
`endif
    case (state)
      ST_BUSY: begin
        work_next = step_work_c;
        cnt_next  = cnt - CNT_W'(1);
`ifdef CC_SEQ_ALU_MUL_EN
        mcand_next = step_mcand_c;
        acc_next   = step_acc_c;
`endif
        if (cnt == CNT_W'(1)) begin
          result_c = step_work_c;
`ifdef CC_SEQ_ALU_MUL_EN
          if (mode == SH_MUL) begin
            result_c        = step_acc_c;
            flags_c[FLAG_N] = step_acc_c[W-1];
            flags_c[FLAG_Z] = (step_acc_c == '0);
            flags_c[FLAG_V] = 1'b0;
            flags_c[FLAG_C] = 1'b0;
          end
`endif
        end
      end
      default: begin
        if (start) begin
          if (multi_c) begin
            work_next = a;
            cnt_next  = CNT_W'(shamt);
            mode_next = (sel == OP_SRL) ? SH_SRL : (sel == OP_SLL) ? SH_SLL : SH_SRA;
`ifdef CC_SEQ_ALU_MUL_EN
            if (sel == OP_F) begin
              work_next  = b;
              mcand_next = a;
              acc_next   = '0;
              cnt_next   = CNT_W'(W);
              mode_next  = SH_MUL;
            end
`endif
          end else begin
            result_c = op_res_c;
            if (op_cc_c) flags_c = op_flags_c;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      flags  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      work   <= '0;
      cnt    <= '0;
      mode   <= SH_SRL;
`ifdef CC_SEQ_ALU_MUL_EN
      mcand  <= '0;
      acc    <= '0;
`endif
    end else begin
      result <= result_c;
      flags  <= flags_c;
      busy   <= busy_c;
      done   <= done_c;
      work   <= work_next;
      cnt    <= cnt_next;
      mode   <= mode_next;
`ifdef CC_SEQ_ALU_MUL_EN
      mcand  <= mcand_next;
      acc    <= acc_next;
`endif
    end
  end

  assign CC_SEQ_ALU_DataBUS_Out      = result;
  assign CC_SEQ_ALU_Busy_OutHigh     = busy;
  assign CC_SEQ_ALU_Done_OutHigh     = done;
  assign CC_SEQ_ALU_Negative_OutHigh = flags[FLAG_N];
  assign CC_SEQ_ALU_Zero_OutHigh     = flags[FLAG_Z];
  assign CC_SEQ_ALU_Overflow_OutHigh = flags[FLAG_V];
  assign CC_SEQ_ALU_Carry_OutHigh    = flags[FLAG_C];

endmodule
